ram_clear_sequencer: RTL and testbench
======================================

// Module: ram_clear_sequencer
// PURPOSE
//   Initiator-side controller for a true_dualport_ram instance. Replaces the single-cycle
//   bulk clear with a multi-cycle zeroing sweep on both RAM ports (two entries/cycle).
//   Muxes a single client request channel onto port A while no sweep is running.
//   Sits between the owning pipeline structure (predictor/tag tables) and its RAM.
// PARAMETERS
//   ADDRLEN         10    RAM address width
//   DATALEN         2     RAM data width
//   DEPTH           1024  entries to clear; 2 <= DEPTH <= 2**ADDRLEN
//   CLEAR_ON_RESET  0     1: sweep starts automatically when reset_x deasserts
// PORTS
//   clk         in   1        clock, all state on posedge
//   reset_x     in   1        async active-low reset
//   clear_req   in   1        start sweep (level, sampled in IDLE only)
//   clear_busy  out  1        sweep in progress
//   clear_done  out  1        one-cycle pulse, sweep finished
//   req_valid   in   1        client request valid
//   req_ready   out  1        client request accepted when valid&ready
//   req_we      in   1        1 = write, 0 = read
//   req_addr    in   ADDRLEN  client address
//   req_wdata   in   DATALEN  client write data
//   rsp_valid   out  1        read data valid (reads only)
//   rsp_rdata   out  DATALEN  read data
//   ram_addra   out  ADDRLEN  RAM port A address
//   ram_wdataa  out  DATALEN  RAM port A write data
//   ram_wea     out  1        RAM port A write enable
//   ram_rdataa  in   DATALEN  RAM port A registered read data
//   ram_addrb   out  ADDRLEN  RAM port B address
//   ram_wdatab  out  DATALEN  RAM port B write data (always 0)
//   ram_web     out  1        RAM port B write enable
// BEHAVIOUR
//   - States: IDLE, SWEEP. Regs: state, ptr[ADDRLEN-1:0], rd_pend, clear_done.
//   - Reset (reset_x low): state=SWEEP if CLEAR_ON_RESET else IDLE; ptr=0; rd_pend=0;
//     clear_done=0. ram_wea/ram_web forced 0 while reset_x is low.
//   - IDLE: clear_req=1 -> SWEEP, ptr=0. clear_req has priority over client:
//     req_ready = (state==IDLE) & ~clear_req. Port A = client path: ram_addra=req_addr,
//     ram_wdataa=req_wdata, ram_wea=req_valid&req_ready&req_we. Port B: addr 0, web 0.
//   - SWEEP: ram_addra=ptr, ram_wea=1, ram_wdataa=0; ram_addrb=ptr+1, ram_wdatab=0,
//     ram_web=(ptr+1 < DEPTH). ptr += 2 each cycle. When ptr+2 >= DEPTH: -> IDLE,
//     clear_done=1 next cycle. Sweep length = ceil(DEPTH/2) cycles. req_ready=0.
//   - clear_busy = (state==SWEEP), combinational from state.
//   - clear_req during SWEEP ignored (no restart, no queuing). Held clear_req in IDLE
//     after done starts a new sweep on the following cycle.
//   - Read: accepted read (valid&ready&~we) sets rd_pend=1 next cycle; rsp_valid=rd_pend,
//     rsp_rdata=ram_rdataa (fixed 1-cycle latency, no backpressure). Writes: no response.
//   - rd_pend clears on its own next cycle; back-to-back reads give back-to-back rsp_valid.
//   - ptr compares done in ADDRLEN+1 bits; no wrap. Odd DEPTH: last cycle writes A only.
//   - Reset mid-sweep: abort immediately, RAM partially cleared, no clear_done pulse;
//     restarts from ptr=0 only if CLEAR_ON_RESET.
//   - Same-address client read of a just-written entry returns the RAM's read-before-write
//     value; no forwarding in this block.
// TESTING
//   1 DEPTH=8: pulse clear_req in IDLE -> busy 4 cycles, A addr 0,2,4,6 / B 1,3,5,7 all
//     we=1 data 0, clear_done 1 cycle after last write, req_ready=0 throughout.
//   2 DEPTH=5: clear_req -> 3 sweep cycles; third cycle ram_wea=1 addr 4, ram_web=0.
//   3 Write addr 3 data 2'b10, then read addr 3 -> rsp_valid exactly 1 cycle after read
//     acceptance, rsp_rdata=2'b10; write produces no rsp_valid.
//   4 clear_req and req_valid same cycle in IDLE -> req_ready=0, request not issued,
//     sweep starts; clear_req re-pulsed mid-sweep -> no extra cycles.
//   5 reset_x low at sweep cycle 2 (CLEAR_ON_RESET=0) -> busy=0, we/web=0 immediately,
//     no clear_done; prefilled entries 4..7 remain nonzero.
//   6 CLEAR_ON_RESET=1, DEPTH=8 -> sweep begins first cycle after reset_x rises, 4 cycles,
//     clear_done pulse, then client read of any address returns 0.

Source files
------------

// File: rtl/ram_clear_sequencer_if.sv
// Client request/response channel between a pipeline structure and the RAM clear sequencer.
// master = client side, slave = sequencer side.
interface ram_clear_sequencer_if #(
  parameter int ADDRLEN = 10,
  parameter int DATALEN = 2
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [ADDRLEN-1:0] req_addr;
  logic [DATALEN-1:0] req_wdata;
  logic               rsp_valid;
  logic [DATALEN-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_clear_sequencer.sv
// Zeroes a true dual-port RAM two entries per cycle (A even, B odd) and, when no
// sweep is running, forwards a single client request channel onto port A.
module ram_clear_sequencer #(
  parameter int ADDRLEN        = 10,
  parameter int DATALEN        = 2,
  parameter int DEPTH          = 1024,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_x,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 clear_done,
  ram_clear_sequencer_if.slave req_if,
  output logic [ADDRLEN-1:0]   ram_addra,
  output logic [DATALEN-1:0]   ram_wdataa,
  output logic                 ram_wea,
  input  logic [DATALEN-1:0]   ram_rdataa,
  output logic [ADDRLEN-1:0]   ram_addrb,
  output logic [DATALEN-1:0]   ram_wdatab,
  output logic                 ram_web
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

  localparam logic [ADDRLEN:0] DEPTH_W     = (ADDRLEN+1)'(DEPTH);
  localparam state_t           RESET_STATE = CLEAR_ON_RESET ? ST_SWEEP : ST_IDLE;

  state_t             state_r, state_nxt_s;
  logic [ADDRLEN-1:0] ptr_r, ptr_nxt_s;
  logic               rd_pend_r, rd_pend_nxt_s;
  logic               clear_done_r, clear_done_nxt_s;
  logic [ADDRLEN:0]   ptr_p1_s, ptr_p2_s;
  logic               req_ready_s, wea_s, web_s;
  logic [ADDRLEN-1:0] addra_s, addrb_s;
  logic [DATALEN-1:0] wdataa_s;

  // One extra bit so the end-of-sweep compare cannot wrap when DEPTH == 2**ADDRLEN.
  assign ptr_p1_s = {1'b0, ptr_r} + (ADDRLEN+1)'(1'b1);
  assign ptr_p2_s = {1'b0, ptr_r} + (ADDRLEN+1)'(2'd2);

  // State, sweep pointer, read-pending and done flags.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_r      <= RESET_STATE;
      ptr_r        <= {ADDRLEN{1'b0}};
      rd_pend_r    <= 1'b0;
      clear_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ptr_r        <= ptr_nxt_s;
      rd_pend_r    <= rd_pend_nxt_s;
      clear_done_r <= clear_done_nxt_s;
    end
  end

  // Next-state and port muxing; a clear request outranks the client in IDLE.
  always_comb begin
    state_nxt_s      = state_r;
    ptr_nxt_s        = ptr_r;
    rd_pend_nxt_s    = 1'b0;
    clear_done_nxt_s = 1'b0;
    req_ready_s      = 1'b0;
    addra_s          = req_if.req_addr;
    wdataa_s         = req_if.req_wdata;
    wea_s            = 1'b0;
    addrb_s          = {ADDRLEN{1'b0}};
    web_s            = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready_s   = ~clear_req;
        wea_s         = req_if.req_valid & req_ready_s & req_if.req_we;
        rd_pend_nxt_s = req_if.req_valid & req_ready_s & ~req_if.req_we;
        if (clear_req) begin
          state_nxt_s = ST_SWEEP;
          ptr_nxt_s   = {ADDRLEN{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        addra_s   = ptr_r;
        wdataa_s  = {DATALEN{1'b0}};
        wea_s     = 1'b1;
        addrb_s   = ptr_p1_s[ADDRLEN-1:0];
        web_s     = (ptr_p1_s < DEPTH_W);
        ptr_nxt_s = ptr_p2_s[ADDRLEN-1:0];
        if (ptr_p2_s >= DEPTH_W) begin
          state_nxt_s      = ST_IDLE;
          clear_done_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_SWEEP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ptr_nxt_s   = {ADDRLEN{1'b0}};
      end
    endcase
  end

  assign clear_busy       = (state_r == ST_SWEEP);
  assign clear_done       = clear_done_r;
  assign req_if.req_ready = req_ready_s;
  assign req_if.rsp_valid = rd_pend_r;
  assign req_if.rsp_rdata = ram_rdataa;
  assign ram_addra        = addra_s;
  assign ram_wdataa       = wdataa_s;
  assign ram_wea          = wea_s & reset_x;
  assign ram_addrb        = addrb_s;
  assign ram_wdatab       = {DATALEN{1'b0}};
  assign ram_web          = web_s & reset_x;

endmodule

// File: tb/tb_ram_clear_sequencer.sv
// Bench for ram_clear_sequencer: three instances (DEPTH 8, DEPTH 5, DEPTH 8 with
// clear-on-reset), each with a small read-before-write dual-port RAM.
module tb_ram_clear_sequencer;
  localparam int AW = 3;
  localparam int DW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance 8: DEPTH 8 ----------------
  logic rst8, clr8, busy8, done8, wea8, web8;
  logic [AW-1:0] addra8, addrb8;
  logic [DW-1:0] wdataa8, wdatab8, rdataa8;
  logic [DW-1:0] mem8 [8] = '{default: 2'b01};
  ram_clear_sequencer_if #(.ADDRLEN(AW), .DATALEN(DW)) if8 ();
  ram_clear_sequencer #(.ADDRLEN(AW), .DATALEN(DW), .DEPTH(8), .CLEAR_ON_RESET(1'b0)) dut8 (
    .clk(clk), .reset_x(rst8), .clear_req(clr8), .clear_busy(busy8), .clear_done(done8),
    .req_if(if8.slave), .ram_addra(addra8), .ram_wdataa(wdataa8), .ram_wea(wea8),
    .ram_rdataa(rdataa8), .ram_addrb(addrb8), .ram_wdatab(wdatab8), .ram_web(web8));
  always @(posedge clk) begin
    rdataa8 <= mem8[addra8];
    if (wea8) mem8[addra8] <= wdataa8;
    if (web8) mem8[addrb8] <= wdatab8;
  end

  // ---------------- instance 5: DEPTH 5 ----------------
  logic rst5, clr5, busy5, done5, wea5, web5;
  logic [AW-1:0] addra5, addrb5;
  logic [DW-1:0] wdataa5, wdatab5, rdataa5;
  logic [DW-1:0] mem5 [8] = '{default: 2'b01};
  ram_clear_sequencer_if #(.ADDRLEN(AW), .DATALEN(DW)) if5 ();
  ram_clear_sequencer #(.ADDRLEN(AW), .DATALEN(DW), .DEPTH(5), .CLEAR_ON_RESET(1'b0)) dut5 (
    .clk(clk), .reset_x(rst5), .clear_req(clr5), .clear_busy(busy5), .clear_done(done5),
    .req_if(if5.slave), .ram_addra(addra5), .ram_wdataa(wdataa5), .ram_wea(wea5),
    .ram_rdataa(rdataa5), .ram_addrb(addrb5), .ram_wdatab(wdatab5), .ram_web(web5));
  always @(posedge clk) begin
    rdataa5 <= mem5[addra5];
    if (wea5) mem5[addra5] <= wdataa5;
    if (web5) mem5[addrb5] <= wdatab5;
  end

  // ---------------- instance c: DEPTH 8, clear on reset ----------------
  logic rstc, clrc, busyc, donec, weac, webc;
  logic [AW-1:0] addrac, addrbc;
  logic [DW-1:0] wdataac, wdatabc, rdataac;
  logic [DW-1:0] memc [8] = '{default: 2'b11};
  ram_clear_sequencer_if #(.ADDRLEN(AW), .DATALEN(DW)) ifc ();
  ram_clear_sequencer #(.ADDRLEN(AW), .DATALEN(DW), .DEPTH(8), .CLEAR_ON_RESET(1'b1)) dutc (
    .clk(clk), .reset_x(rstc), .clear_req(clrc), .clear_busy(busyc), .clear_done(donec),
    .req_if(ifc.slave), .ram_addra(addrac), .ram_wdataa(wdataac), .ram_wea(weac),
    .ram_rdataa(rdataac), .ram_addrb(addrbc), .ram_wdatab(wdatabc), .ram_web(webc));
  always @(posedge clk) begin
    rdataac <= memc[addrac];
    if (weac) memc[addrac] <= wdataac;
    if (webc) memc[addrbc] <= wdatabc;
  end

  typedef struct {
    logic clr, vld, we; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    logic e_ready, e_busy, e_done, e_wea; logic [AW-1:0] e_addra;
    logic e_web; logic [AW-1:0] e_addrb; logic e_rspv; logic [DW-1:0] e_rdata;
  } vec_t;
  vec_t tbl [15];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive8(input int clr, input int vld, input int we, input int addr, input int wdata);
    clr8             = (clr != 0);
    if8.req_valid    = (vld != 0);
    if8.req_we       = (we != 0);
    if8.req_addr     = AW'(addr);
    if8.req_wdata    = DW'(wdata);
  endtask

  task automatic read8(input int addr, input int exp, input string name);
    @(negedge clk); drive8(0, 1, 0, addr, 0);
    @(negedge clk); drive8(0, 0, 0, 0, 0);
    #1;
    check({name, "_rspv"}, int'(if8.rsp_valid), 1);
    check({name, "_rdata"}, int'(if8.rsp_rdata), exp);
  endtask

  // reference model state for the randomized run
  int m_left, m_k, cnt;
  bit m_done, m_rpend;
  int m_rdata;
  int m_mem [8];
  int r_clr, r_vld, r_we, r_addr, r_wdata;

  initial begin
    rst8 = 1'b0; rst5 = 1'b0; rstc = 1'b0;
    clr5 = 1'b0; clrc = 1'b0;
    drive8(0, 0, 0, 0, 0);
    if5.req_valid = 1'b0; if5.req_we = 1'b0; if5.req_addr = '0; if5.req_wdata = '0;
    ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_addr = '0; ifc.req_wdata = '0;

    @(negedge clk); #1;
    check("rst8_busy", int'(busy8), 0);
    check("rst8_done", int'(done8), 0);
    check("rst8_rspv", int'(if8.rsp_valid), 0);
    check("rstc_wea", int'(weac), 0);
    check("rstc_web", int'(webc), 0);
    @(negedge clk); rst8 = 1'b1; rst5 = 1'b1;
    #1 check("rst8_ready", int'(if8.req_ready), 1);

    // clear-on-reset instance: sweep starts the first cycle after release
    @(negedge clk); rstc = 1'b1;
    #1;
    check("cor_first_busy", int'(busyc), 1);
    check("cor_first_wea", int'(weac), 1);
    check("cor_first_addra", int'(addrac), 0);
    cnt = 0;
    for (int i = 0; i < 12 && busyc; i++) begin
      cnt++;
      @(negedge clk); #1;
    end
    check("cor_sweep_len", cnt, 4);
    check("cor_done", int'(donec), 1);
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_we = 1'b0; ifc.req_addr = AW'($urandom_range(0, 7));
    #1 check("cor_done_pulse", int'(donec), 0);
    @(negedge clk); ifc.req_valid = 1'b0;
    #1;
    check("cor_read_rspv", int'(ifc.rsp_valid), 1);
    check("cor_read_zero", int'(ifc.rsp_rdata), 0);

    // odd depth: last sweep cycle writes port A only
    @(negedge clk); clr5 = 1'b1;
    @(negedge clk); clr5 = 1'b0;
    #1;
    check("d5_c1_busy", int'(busy5), 1);
    check("d5_c1_addrb", int'(addrb5), 1);
    check("d5_c1_web", int'(web5), 1);
    @(negedge clk); #1;
    check("d5_c2_addra", int'(addra5), 2);
    check("d5_c2_web", int'(web5), 1);
    @(negedge clk); #1;
    check("d5_c3_wea", int'(wea5), 1);
    check("d5_c3_addra", int'(addra5), 4);
    check("d5_c3_web", int'(web5), 0);
    @(negedge clk); #1;
    check("d5_busy_end", int'(busy5), 0);
    check("d5_done", int'(done5), 1);
    check("d5_mem4", int'(mem5[4]), 0);
    check("d5_mem5_kept", int'(mem5[5]), 1);

    // table: client path, clear priority, full DEPTH 8 sweep, re-pulse ignored
    tbl[0]  = '{1'b0,1'b1,1'b1,3'd3,2'd2, 1'b1,1'b0,1'b0,1'b1,3'd3,1'b0,3'd0,1'b0,2'd0};
    tbl[1]  = '{1'b0,1'b1,1'b0,3'd3,2'd0, 1'b1,1'b0,1'b0,1'b0,3'd3,1'b0,3'd0,1'b0,2'd0};
    tbl[2]  = '{1'b0,1'b0,1'b0,3'd0,2'd0, 1'b1,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b1,2'd2};
    tbl[3]  = '{1'b0,1'b1,1'b1,3'd5,2'd3, 1'b1,1'b0,1'b0,1'b1,3'd5,1'b0,3'd0,1'b0,2'd0};
    tbl[4]  = '{1'b0,1'b1,1'b0,3'd5,2'd0, 1'b1,1'b0,1'b0,1'b0,3'd5,1'b0,3'd0,1'b0,2'd0};
    tbl[5]  = '{1'b0,1'b1,1'b0,3'd3,2'd0, 1'b1,1'b0,1'b0,1'b0,3'd3,1'b0,3'd0,1'b1,2'd3};
    tbl[6]  = '{1'b0,1'b1,1'b0,3'd1,2'd0, 1'b1,1'b0,1'b0,1'b0,3'd1,1'b0,3'd0,1'b1,2'd2};
    tbl[7]  = '{1'b1,1'b1,1'b1,3'd2,2'd3, 1'b0,1'b0,1'b0,1'b0,3'd2,1'b0,3'd0,1'b1,2'd1};
    tbl[8]  = '{1'b0,1'b0,1'b0,3'd0,2'd0, 1'b0,1'b1,1'b0,1'b1,3'd0,1'b1,3'd1,1'b0,2'd0};
    tbl[9]  = '{1'b1,1'b1,1'b0,3'd3,2'd0, 1'b0,1'b1,1'b0,1'b1,3'd2,1'b1,3'd3,1'b0,2'd0};
    tbl[10] = '{1'b1,1'b0,1'b0,3'd0,2'd0, 1'b0,1'b1,1'b0,1'b1,3'd4,1'b1,3'd5,1'b0,2'd0};
    tbl[11] = '{1'b0,1'b0,1'b0,3'd0,2'd0, 1'b0,1'b1,1'b0,1'b1,3'd6,1'b1,3'd7,1'b0,2'd0};
    tbl[12] = '{1'b0,1'b1,1'b0,3'd5,2'd0, 1'b1,1'b0,1'b1,1'b0,3'd5,1'b0,3'd0,1'b0,2'd0};
    tbl[13] = '{1'b0,1'b1,1'b0,3'd3,2'd0, 1'b1,1'b0,1'b0,1'b0,3'd3,1'b0,3'd0,1'b1,2'd0};
    tbl[14] = '{1'b0,1'b0,1'b0,3'd0,2'd0, 1'b1,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b1,2'd0};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive8(tbl[i].clr, tbl[i].vld, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      #1;
      check($sformatf("tbl%0d_ready", i), int'(if8.req_ready), int'(tbl[i].e_ready));
      check($sformatf("tbl%0d_busy", i), int'(busy8), int'(tbl[i].e_busy));
      check($sformatf("tbl%0d_done", i), int'(done8), int'(tbl[i].e_done));
      check($sformatf("tbl%0d_wea", i), int'(wea8), int'(tbl[i].e_wea));
      check($sformatf("tbl%0d_addra", i), int'(addra8), int'(tbl[i].e_addra));
      check($sformatf("tbl%0d_web", i), int'(web8), int'(tbl[i].e_web));
      check($sformatf("tbl%0d_addrb", i), int'(addrb8), int'(tbl[i].e_addrb));
      check($sformatf("tbl%0d_wdatab", i), int'(wdatab8), 0);
      check($sformatf("tbl%0d_rspv", i), int'(if8.rsp_valid), int'(tbl[i].e_rspv));
      if (tbl[i].e_busy) check($sformatf("tbl%0d_wdataa", i), int'(wdataa8), 0);
      if (tbl[i].e_rspv) check($sformatf("tbl%0d_rdata", i), int'(if8.rsp_rdata), int'(tbl[i].e_rdata));
    end
    @(negedge clk); drive8(0, 0, 0, 0, 0);

    // reset during the second sweep cycle aborts the sweep
    for (int i = 4; i < 8; i++) begin
      @(negedge clk); drive8(0, 1, 1, i, 3);
    end
    @(negedge clk); drive8(1, 0, 0, 0, 0);
    @(negedge clk); drive8(0, 0, 0, 0, 0);
    #1 check("abort_sweep_started", int'(busy8), 1);
    @(negedge clk); rst8 = 1'b0;
    #1;
    check("abort_busy", int'(busy8), 0);
    check("abort_wea", int'(wea8), 0);
    check("abort_web", int'(web8), 0);
    @(negedge clk); #1 check("abort_no_done_a", int'(done8), 0);
    @(negedge clk); rst8 = 1'b1;
    #1;
    check("abort_no_done_b", int'(done8), 0);
    check("abort_idle", int'(busy8), 0);
    for (int i = 4; i < 8; i++) read8(i, 3, $sformatf("abort_keep%0d", i));
    read8(0, 0, "abort_cleared0");

    // randomized traffic against the reference model
    m_left = 0; m_k = 0; m_done = 1'b0; m_rpend = 1'b0; m_rdata = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      r_clr   = (cyc == 0) ? 1 : int'($urandom_range(0, 19) == 0);
      r_vld   = int'($urandom_range(0, 9) < 6);
      r_we    = int'($urandom_range(0, 1));
      r_addr  = int'($urandom_range(0, 7));
      r_wdata = int'($urandom_range(0, 3));
      drive8(r_clr, r_vld, r_we, r_addr, r_wdata);
      #1;
      check("rnd_done", int'(done8), int'(m_done));
      check("rnd_rspv", int'(if8.rsp_valid), int'(m_rpend));
      if (m_rpend) check("rnd_rdata", int'(if8.rsp_rdata), m_rdata);
      if (m_left > 0) begin
        check("rnd_busy", int'(busy8), 1);
        check("rnd_ready", int'(if8.req_ready), 0);
        check("rnd_wea", int'(wea8), 1);
        check("rnd_addra", int'(addra8), 2 * m_k);
        check("rnd_wdataa", int'(wdataa8), 0);
        check("rnd_web", int'(web8), int'(2 * m_k + 1 < 8));
        check("rnd_addrb", int'(addrb8), 2 * m_k + 1);
        m_mem[2 * m_k] = 0;
        if (2 * m_k + 1 < 8) m_mem[2 * m_k + 1] = 0;
        m_rpend = 1'b0;
        m_k++;
        m_left--;
        m_done = (m_left == 0);
      end else begin
        check("rnd_busy", int'(busy8), 0);
        check("rnd_ready", int'(if8.req_ready), int'(r_clr == 0));
        check("rnd_wea", int'(wea8), int'(r_vld != 0 && r_clr == 0 && r_we != 0));
        check("rnd_addra", int'(addra8), r_addr);
        check("rnd_web", int'(web8), 0);
        m_rpend = (r_vld != 0 && r_clr == 0 && r_we == 0);
        m_rdata = m_mem[r_addr];
        if (r_vld != 0 && r_clr == 0 && r_we != 0) m_mem[r_addr] = r_wdata;
        m_done = 1'b0;
        if (r_clr != 0) begin
          m_left = (8 + 1) / 2;
          m_k    = 0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
